// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Executes one RV32I load or store per accepted start. The effective address
//   (base + offset) is computed on accept, a single bus request is issued with
//   lane-aligned byte enables and store data, and the load result is extracted
//   from the returned word and sign/zero extended. A REQ-cycle counter aborts
//   the access with err=1 if bus_ack does not arrive within TIMEOUT_CYCLES.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses complete
//                          immediately with err=1 and no bus request. When not
//                          defined, the offending low address bits are ignored
//                          and the access proceeds normally.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous active-high reset
//   start      in   1   one-cycle access request (accepted only when idle)
//   lsu_func   in   4   bit3 = store, bits2:0 = RV32I funct3
//   base       in  32   rs1 value
//   offset     in  32   sign-extended immediate
//   wdata      in  32   rs2 value for stores
//   busy       out  1   high from the cycle after accept through the done cycle
//   done       out  1   one-cycle completion pulse
//   err        out  1   error flag, qualified by done
//   rdata      out 32   load result, valid with done (0 for stores)
//   bus_req    out  1   bus request
//   bus_we     out  1   bus write enable
//   bus_addr   out 30   word address ea[31:2]
//   bus_be     out  4   byte enables
//   bus_wdata  out 32   lane-replicated store data
//   bus_rdata  in  32   bus read data, valid with bus_ack
//   bus_ack    in   1   completes the current request in the same cycle
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  lsu_func,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value on the last REQ cycle that may still see an ack.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [3:0]  r_func;
  logic [1:0]  r_lane;
  logic        r_err;
  logic [31:0] r_rdata;

  logic [31:0] w_ea;
  logic        w_legal;
  logic        w_misalign;
  logic        w_fault;
  logic [3:0]  w_be;
  logic [1:0]  w_lane;
  logic [31:0] w_store_data;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic        w_timeout;

  // ---------------------------------------------------------------------------
  // Decode of the access presented with start
  // ---------------------------------------------------------------------------
  assign w_ea = base + offset;

  always_comb begin
    w_legal = 1'b0;
    unique case (lsu_func)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010: w_legal = 1'b1;
      default:                   w_legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((lsu_func[1:0] == 2'b01) && w_ea[0]) ||
                      ((lsu_func[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = !w_legal || w_misalign;

  // Lowest byte lane touched. Halves ignore ea[0] and words always start at
  // lane 0, so a misaligned access without trapping stays within one word.
  always_comb begin
    w_lane = 2'b00;
    w_be   = 4'b1111;
    unique case (lsu_func[1:0])
      2'b00: begin
        w_lane = w_ea[1:0];
        w_be   = 4'b0001 << w_ea[1:0];
      end
      2'b01: begin
        w_lane = {w_ea[1], 1'b0};
        w_be   = w_ea[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_lane = 2'b00;
        w_be   = 4'b1111;
      end
    endcase
  end

  // Store data replicated so every enabled lane carries the right byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_store_lane
      assign w_store_data[8*gi +: 8] =
        (lsu_func[1:0] == 2'b00) ? wdata[7:0] :
        (lsu_func[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                   wdata[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load data extraction from the returned word
  // ---------------------------------------------------------------------------
  assign w_shifted = bus_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load_data = 32'h0;
    unique case (r_func)
      4'b0000: w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      4'b0001: w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      4'b0010: w_load_data = w_shifted;
      4'b0100: w_load_data = {24'h0, w_shifted[7:0]};
      4'b0101: w_load_data = {16'h0, w_shifted[15:0]};
      default: w_load_data = 32'h0;  // stores return zero
    endcase
  end

  assign w_timeout = (r_cnt == TO_LAST);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = w_fault ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_ack || w_timeout) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'h0;
      r_func    <= 4'h0;
      r_lane    <= 2'b00;
      r_err     <= 1'b0;
      r_rdata   <= 32'h0;
      bus_we    <= 1'b0;
      bus_addr  <= 30'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= 16'h0;
            r_func  <= lsu_func;
            r_lane  <= w_lane;
            r_err   <= w_fault;
            r_rdata <= 32'h0;
            // Bus fields only change when a request will actually be issued,
            // so they are stable for the whole REQ phase.
            if (!w_fault) begin
              bus_we    <= lsu_func[3];
              bus_addr  <= w_ea[31:2];
              bus_be    <= w_be;
              bus_wdata <= w_store_data;
            end
          end
        end
        ST_REQ: begin
          // An ack on the final counted cycle still completes normally.
          if (bus_ack) begin
            r_rdata <= w_load_data;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DONE: r_err <= 1'b0;
        default: r_err <= 1'b0;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign bus_req = (r_state == ST_REQ);
  assign done    = (r_state == ST_DONE);
  assign err     = r_err;
  assign rdata   = r_rdata;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for bus_ack before abort (1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to perform the access described by the operand inputs.
REQ-005 SHALL have port lsu_func, input, 4, bit3 = store and bits2:0 = RV32I funct3.
REQ-006 SHALL have port base, input, 32, rs1 value.
REQ-007 SHALL have port offset, input, 32, sign-extended immediate from decode.
REQ-008 SHALL have port wdata, input, 32, rs2 value for stores.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, qualified by done; high for illegal func, timeout or misalignment.
REQ-012 SHALL have port rdata, output, 32, load result for register write-back, valid with done.
REQ-013 SHALL have port bus_req, output, 1, bus request.
REQ-014 SHALL have port bus_we, output, 1, bus write enable.
REQ-015 SHALL have port bus_addr, output, 30, word address [31:2].
REQ-016 SHALL have port bus_be, output, 4, byte enables.
REQ-017 SHALL have port bus_wdata, output, 32, lane-aligned store data.
REQ-018 SHALL have port bus_rdata, input, 32, bus read data, valid with bus_ack.
REQ-019 SHALL have port bus_ack, input, 1, completes the current request in the same cycle.

Function
REQ-020 SHALL implement states IDLE, REQ and DONE.
REQ-021 SHALL accept start only in IDLE, latching ea = base+offset (mod 2^32), lsu_func and wdata; start while not IDLE SHALL be ignored.
REQ-022 SHALL, on accept with a legal aligned func, enter REQ with bus_req=1 from the next cycle; bus_addr, bus_we, bus_be and bus_wdata SHALL be stable while bus_req=1.
REQ-023 SHALL accept only these legal funcs: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 1000 SB, 1001 SH, 1010 SW. Any other func SHALL go IDLE->DONE with err=1 and no bus request.
REQ-024 SHALL generate byte enables as follows: byte = 0001<<ea[1:0]; half = 0011<<ea[1:0]; word = 1111. Store data SHALL be replicated across lanes (byte x4, half x2).
REQ-025 SHALL, in REQ with bus_ack=1, drop bus_req next cycle, enter DONE, and register rdata: the selected lane shifted down, then sign-extended (LB/LH) or zero-extended (LBU/LHU). Store rdata SHALL be 0.
REQ-026 SHALL make done=1 for exactly one cycle in DONE, then return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-027 SHALL have latency start to done = 2 cycles plus bus wait cycles (ack in the first REQ cycle gives done at start+2).
REQ-028 SHALL count REQ cycles with a 16-bit counter; when the count reaches TIMEOUT_CYCLES without ack, go to DONE with err=1 and bus_req=0 next cycle.
REQ-029 SHALL treat bus_ack outside REQ as ignored.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, force state IDLE and outputs busy=0, done=0, err=0, rdata=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, counter=0.
REQ-031 SHALL, on reset mid-transaction, abandon the transaction with no done pulse; start coincident with reset SHALL be ignored.

Configuration
REQ-032 SHALL, with LSU_MISALIGN_TRAP_EN defined, send a half access with ea[0]=1 or a word access with ea[1:0]!=0 to DONE with err=1 and no bus request.
REQ-033 SHALL, without LSU_MISALIGN_TRAP_EN, ignore the offending low ea bits for misaligned accesses (half uses ea[1], word uses lane 0), access normally with err=0, and never report misalignment.

Verification
REQ-034 SHALL be checked with: LW base=0x100, offset=4, bus_rdata=0xDEADBEEF, ack in the first REQ cycle -> bus_addr=0x41, bus_be=1111, done at start+2, rdata=0xDEADBEEF, err=0.
REQ-035 SHALL be checked with: LB then LBU at ea=0x103, bus_rdata=0x80FF0000 -> bus_be=1000; rdata=0xFFFFFF80 for LB and 0x00000080 for LBU.
REQ-036 SHALL be checked with: SH ea=0x202, wdata=0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, done after ack.
REQ-037 SHALL be checked with: LW and ack never asserted, TIMEOUT_CYCLES=4 -> bus_req high for 4 cycles, then done=1, err=1.
REQ-038 SHALL be checked with: LH at ea=0x101 -> with the macro, err=1 at start+1 and no bus_req; without it, bus_be=0011 and err=0.
REQ-039 SHALL be checked with: reset asserted during REQ -> bus_req=0 and busy=0 the next cycle, no done; then illegal func 0111 -> done=1, err=1, no bus_req.
